// File: rtl/twos_comp_seq.sv
// Digit-serial two's-complement unit: pass / negate / abs / negative-abs, DIGIT bits per cycle, LSB digit first.
// Build option: define TWOS_COMP_SEQ_SAT_EN to saturate the overflowing case to the maximum positive value.
module twos_comp_seq #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic [1:0]       dbg_state_o
);

  // Handshake: an operand transfers on a rising edge where in_valid & in_ready;
  // a result transfers on a rising edge where out_valid & out_ready.
  // WIDTH must be a multiple of DIGIT.
  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0]    K_LAST  = KW'(N - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [KW-1:0]    k_q, k_d;
  logic             invert_q, invert_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic                   accept;
  logic                   invert_in;
  logic [DIGIT:0]         sum_w;
  logic [WIDTH+DIGIT-1:0] opnd_cat;
  logic [WIDTH+DIGIT-1:0] res_cat;

  assign accept = in_valid & in_ready;

  always_comb begin
    invert_in = 1'b0;
    case (op)
      2'b00:   invert_in = 1'b0;
      2'b01:   invert_in = 1'b1;
      2'b10:   invert_in = operand[WIDTH-1];
      default: invert_in = ~operand[WIDTH-1];
    endcase
  end

  // The operand shifts down one digit per RUN edge so the current digit is always at the bottom;
  // the result digit enters at the top, leaving the LSB digit at bit 0 after N edges.
  assign sum_w    = {1'b0, operand_q[DIGIT-1:0] ^ {DIGIT{invert_q}}} + (DIGIT+1)'(carry_q);
  assign opnd_cat = {{DIGIT{1'b0}}, operand_q};
  assign res_cat  = {sum_w[DIGIT-1:0], result_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (k_q == K_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    dbg_state_o = state_q;
  end

  always_comb begin
    operand_d = operand_q;
    result_d  = result_q;
    k_d       = k_q;
    invert_d  = invert_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    if (accept) begin
      operand_d = operand;
      invert_d  = invert_in;
      carry_d   = invert_in;
      k_d       = '0;
      ovf_d     = invert_in & (operand == MIN_NEG);
    end else if (state_q == RUN) begin
      operand_d = opnd_cat[WIDTH+DIGIT-1:DIGIT];
      result_d  = res_cat[WIDTH+DIGIT-1:DIGIT];
      carry_d   = sum_w[DIGIT];
      k_d       = k_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_q <= '0;
      result_q  <= '0;
      k_q       <= '0;
      invert_q  <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      operand_q <= operand_d;
      result_q  <= result_d;
      k_q       <= k_d;
      invert_q  <= invert_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ovf = ovf_q;

`ifdef TWOS_COMP_SEQ_SAT_EN
  assign result = ovf_q ? MAX_POS : result_q;
`else
  // Negating the most negative value wraps back onto itself, so no substitution is needed.
  assign result = result_q;
`endif

endmodule

// File: tb/tb_twos_comp_seq.sv
// Directed + random bench for twos_comp_seq: DIGIT=8 main instance, DIGIT=1 and DIGIT=32 side instances.
// Expected results come from a behavioural model pushed into a scoreboard queue at stimulus time.
module tb_twos_comp_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, ovf;
  logic [31:0] operand, result;
  logic [1:0]  op, dbg_state;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
  logic [31:0] a_operand, a_result;
  logic [1:0]  a_op, a_dbg_state;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
  logic [31:0] b_operand, b_result;
  logic [1:0]  b_op, b_dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  twos_comp_seq #(.WIDTH(32), .DIGIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand(operand), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .dbg_state_o(dbg_state)
  );

  twos_comp_seq #(.WIDTH(32), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .operand(a_operand), .op(a_op), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .result(a_result), .ovf(a_ovf), .dbg_state_o(a_dbg_state)
  );

  twos_comp_seq #(.WIDTH(32), .DIGIT(32)) dut_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .operand(b_operand), .op(b_op), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .result(b_result), .ovf(b_ovf), .dbg_state_o(b_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, result} for one operation.
  function automatic logic [32:0] model(input logic [1:0] o, input logic [31:0] x);
    logic        inv;
    logic        v;
    logic [31:0] r;
    case (o)
      2'b00:   inv = 1'b0;
      2'b01:   inv = 1'b1;
      2'b10:   inv = x[31];
      default: inv = ~x[31];
    endcase
    r = inv ? (32'd0 - x) : x;
    v = inv && (x == 32'h8000_0000);
`ifdef TWOS_COMP_SEQ_SAT_EN
    if (v) r = 32'h7FFF_FFFF;
`endif
    return {v, r};
  endfunction

  // One transaction on the DIGIT=8 instance; hold = cycles to keep out_ready low in DONE.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input int hold);
    logic [32:0] e;
    int          edges;
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    op = o;
    operand = x;
    in_valid = 1'b1;
    exp_q.push_back(model(o, x));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    operand = $urandom;
    op = 2'($urandom_range(0, 3));
    edges = 0;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("latency_edges", 32'(edges), 32'd4);
    e = exp_q.pop_front();
    check("result", result, e[31:0]);
    check("ovf", 32'(ovf), 32'(e[32]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_result", result, e[31:0]);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_take", 32'(in_ready), 32'd1);
    check("out_valid_after_take", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat_a;
    int lat_b;
    logic [1:0]  r_op;
    logic [31:0] r_x;

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; operand = '0; op = '0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_operand = '0; a_op = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_operand = '0; b_op = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_state_d1", 32'(a_dbg_state), 32'd0);
    check("rst_state_d32", 32'(b_dbg_state), 32'd0);
    rst_n = 1'b1;

    // Core operations and the most-negative boundary.
    run_op(2'b01, 32'h0000_0005, 0);
    run_op(2'b10, 32'hFFFF_FFF6, 0);
    run_op(2'b10, 32'h0000_000A, 0);
    run_op(2'b11, 32'h0000_000A, 0);
    run_op(2'b01, 32'h8000_0000, 0);
    run_op(2'b11, 32'h8000_0000, 0);
    run_op(2'b10, 32'h8000_0000, 0);
    run_op(2'b11, 32'h0000_0000, 0);
    run_op(2'b01, 32'h0000_0000, 0);
    run_op(2'b00, 32'hDEAD_BEEF, 0);

    // Back-pressure in DONE.
    run_op(2'b01, 32'h0000_0007, 3);

    // Reset in RUN after two RUN edges discards the operation.
    @(negedge clk);
    check("rst_pulse_in_ready_pre", 32'(in_ready), 32'd1);
    op = 2'b01; operand = 32'h0000_0033; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_pulse_out_valid", 32'(out_valid), 32'd0);
    check("rst_pulse_in_ready", 32'(in_ready), 32'd1);
    check("rst_pulse_result", result, 32'd0);
    check("rst_pulse_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_pulse_no_result", 32'(out_valid), 32'd0);
    end
    run_op(2'b00, 32'h1234_5678, 0);

    // Random operations.
    for (int i = 0; i < 8; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_x  = (i == 0) ? 32'h7FFF_FFFF : 32'($urandom);
      run_op(r_op, r_x, $urandom_range(0, 2));
    end

    // DIGIT=1 and DIGIT=32 builds in parallel: negate 1.
    @(negedge clk);
    check("d1_in_ready", 32'(a_in_ready), 32'd1);
    check("d32_in_ready", 32'(b_in_ready), 32'd1);
    a_op = 2'b01; a_operand = 32'd1; a_in_valid = 1'b1;
    b_op = 2'b01; b_operand = 32'd1; b_in_valid = 1'b1;
    exp_q.push_back(model(2'b01, 32'd1));
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0; a_operand = 32'($urandom);
    b_in_valid = 1'b0; b_operand = 32'($urandom);
    lat_a = -1;
    lat_b = -1;
    if (a_out_valid) lat_a = 0;
    if (b_out_valid) lat_b = 0;
    for (int e = 1; e <= 100 && (lat_a < 0 || lat_b < 0); e++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_out_valid && lat_a < 0) lat_a = e;
      if (b_out_valid && lat_b < 0) lat_b = e;
    end
    check("d1_latency", 32'(lat_a), 32'd32);
    check("d32_latency", 32'(lat_b), 32'd1);
    begin
      logic [32:0] e1;
      e1 = exp_q.pop_front();
      check("d1_result", a_result, e1[31:0]);
      check("d32_result", b_result, e1[31:0]);
      check("d1_ovf", 32'(a_ovf), 32'(e1[32]));
      check("d32_ovf", 32'(b_ovf), 32'(e1[32]));
    end
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    check("d1_in_ready_after", 32'(a_in_ready), 32'd1);
    check("d32_in_ready_after", 32'(b_in_ready), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/twos_comp_seq.md
TWOS_COMP_SEQ -- requirements
Module: twos_comp_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 8, bits processed per cycle; WIDTH mod DIGIT == 0 is required and N = WIDTH/DIGIT.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  operand offered.
REQ-006 The block SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 The block SHALL have port operand  input  WIDTH  two's-complement input value.
REQ-008 The block SHALL have port op  input  2  operation: 00 pass, 01 negate, 10 abs, 11 negative-abs (-|x|).
REQ-009 The block SHALL have port out_valid  output  1  result available.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 The block SHALL have port result  output  WIDTH  computed value.
REQ-012 The block SHALL have port ovf  output  1  result not representable.

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in RUN and DONE it SHALL be 0.
REQ-015 On an edge with in_valid & in_ready, the block SHALL latch operand and op, set invert, preload carry = invert, clear digit counter k, and enter RUN.
REQ-016 invert SHALL be: pass 0; negate 1; abs = operand[WIDTH-1]; negative-abs = ~operand[WIDTH-1].
REQ-017 Each RUN edge SHALL compute digit k as {carry_out, result digit} = (operand digit k XOR {DIGIT{invert}}) + carry, store carry_out, and increment k (LSB digit first).
REQ-018 After the RUN edge for k = N-1, the block SHALL enter DONE; out_valid SHALL be 1 exactly N edges after the accepting edge.
REQ-019 In DONE, result and ovf SHALL be held stable until out_valid & out_ready, then the block SHALL enter IDLE; in_ready SHALL return on the following cycle (no same-cycle reaccept).
REQ-020 ovf SHALL be 1 iff invert = 1 and operand = 1 followed by WIDTH-1 zeros; pass and negative-abs therefore never overflow.
REQ-021 With N = 1 (DIGIT = WIDTH), RUN SHALL last one edge; with DIGIT = 1, RUN SHALL last WIDTH edges.
REQ-022 Inputs other than in_valid SHALL be ignored outside the accepting edge; out_ready SHALL be ignored outside DONE.

Reset
REQ-023 While rst_n = 0, the block SHALL immediately force state IDLE, k = 0, carry = 0, result = 0, ovf = 0, out_valid = 0, in_ready = 1.
REQ-024 Reset asserted in RUN or DONE SHALL discard the operation with no result produced.

Configuration
REQ-025 The block SHALL support exactly one macro, TWOS_COMP_SEQ_SAT_EN.
REQ-026 With TWOS_COMP_SEQ_SAT_EN defined, when ovf = 1 the block SHALL present result = 0 followed by WIDTH-1 ones (maximum positive).
REQ-027 Without TWOS_COMP_SEQ_SAT_EN, when ovf = 1 the block SHALL present the wrapped value 1 followed by WIDTH-1 zeros.
REQ-028 ovf SHALL be reported identically in both builds.

Verification (WIDTH = 32, DIGIT = 8)
REQ-029 The bench SHALL cover: negate 0x00000005 -> result 0xFFFFFFFB, ovf 0, out_valid 4 edges after acceptance.
REQ-030 The bench SHALL cover: abs 0xFFFFFFF6 -> result 0x0000000A; abs 0x0000000A -> 0x0000000A; negative-abs 0x0000000A -> 0xFFFFFFF6.
REQ-031 The bench SHALL cover: negate 0x80000000 -> ovf 1, result 0x80000000 without SAT_EN and 0x7FFFFFFF with it; negative-abs 0x80000000 -> result 0x80000000, ovf 0.
REQ-032 The bench SHALL cover: out_ready held low 3 cycles in DONE -> result stable, in_ready 0 throughout; out_ready high -> IDLE, in_ready 1 on the next cycle.
REQ-033 The bench SHALL cover: rst_n pulsed low after 2 RUN edges -> out_valid 0, in_ready 1 immediately; next operand pass 0x12345678 -> 0x12345678.
REQ-034 The bench SHALL cover: rebuild with DIGIT = 1 and DIGIT = 32, negate 0x00000001 -> 0xFFFFFFFF after 32 and 1 edges respectively.
